pattern_serializer: RTL and testbench

Parallel-to-serial pattern source that drives the sequence-detector FSM's `in_put` line. A WIDTH-bit test pattern is loaded in one cycle and shifted out MSB-first, one bit per BIT_CYCLES clocks, optionally repeating, so the detector can be exercised from switches instead of a hand-written bit stream. The block sits directly upstream of the detector and shares its clock and reset.

---
 rtl/pattern_serializer_if.sv | 9 +
 rtl/pattern_serializer.sv | 82 ++++++++
 tb/tb_pattern_serializer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pattern_serializer_if.sv
// pattern_serializer_if: load/pattern/control inputs and serial outputs of the pattern serializer
interface pattern_serializer_if #(parameter int WIDTH = 8);
    localparam int IW = $clog2(WIDTH);
    logic load, cont, stop, in_put, bit_valid, busy, done;
    logic [WIDTH-1:0] data;
    logic [IW-1:0] bit_idx;
    modport master(output load, data, cont, stop, input in_put, bit_valid, busy, done, bit_idx);
    modport slave(input load, data, cont, stop, output in_put, bit_valid, busy, done, bit_idx);
endinterface

// File: rtl/pattern_serializer.sv
// pattern_serializer: loads a WIDTH-bit pattern and shifts it out MSB-first, BIT_CYCLES clocks per bit
module pattern_serializer #(
    parameter int WIDTH = 8,
    parameter int BIT_CYCLES = 1
) (
    input logic clk,
    input logic reset,
    pattern_serializer_if.slave s
);
    localparam int IW = $clog2(WIDTH);
    localparam int PW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t st;
    logic [WIDTH-1:0] pat, sh;
    logic [PW-1:0] pre;
    logic wrap;
    assign wrap = pre == PW'(BIT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= IDLE;
            pat <= '0;
            sh <= '0;
            pre <= '0;
            s.in_put <= 1'b0;
            s.bit_valid <= 1'b0;
            s.busy <= 1'b0;
            s.done <= 1'b0;
            s.bit_idx <= '0;
        end else begin
            case (st)
                IDLE: if (s.load && !s.stop) begin
                    st <= SHIFT;
                    pat <= s.data;
                    sh <= s.data;
                    pre <= '0;
                    s.in_put <= s.data[WIDTH-1];
                    s.bit_valid <= 1'b1;
                    s.busy <= 1'b1;
                    s.bit_idx <= IW'(WIDTH - 1);
                end
                SHIFT: if (s.stop) begin
                    st <= IDLE;
                    sh <= '0;
                    pre <= '0;
                    s.in_put <= 1'b0;
                    s.bit_valid <= 1'b0;
                    s.busy <= 1'b0;
                    s.bit_idx <= '0;
                end else if (!wrap) begin
                    pre <= pre + 1'b1;
                    s.bit_valid <= 1'b0;
                end else if (s.bit_idx != '0) begin
                    pre <= '0;
                    sh <= sh << 1;
                    s.in_put <= sh[WIDTH-2];
                    s.bit_valid <= 1'b1;
                    s.bit_idx <= s.bit_idx - 1'b1;
                end else if (s.cont) begin
                    // repeat: next frame's MSB follows bit 0 with no gap
                    pre <= '0;
                    sh <= pat;
                    s.in_put <= pat[WIDTH-1];
                    s.bit_valid <= 1'b1;
                    s.bit_idx <= IW'(WIDTH - 1);
                end else begin
                    st <= DONE;
                    pre <= '0;
                    sh <= '0;
                    s.in_put <= 1'b0;
                    s.bit_valid <= 1'b0;
                    s.busy <= 1'b0;
                    s.done <= 1'b1;
                    s.bit_idx <= '0;
                end
                default: begin
                    st <= IDLE;
                    s.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: vector table, corner sequences and random stimulus against a frame-time model
module tb_pattern_serializer;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset, load, cont, stop;
    logic [W-1:0] data;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    pattern_serializer_if #(.WIDTH(W)) a();
    pattern_serializer_if #(.WIDTH(W)) b();
    assign a.load = load;
    assign a.data = data;
    assign a.cont = cont;
    assign a.stop = stop;
    assign b.load = load;
    assign b.data = data;
    assign b.cont = cont;
    assign b.stop = stop;

    pattern_serializer #(.WIDTH(W), .BIT_CYCLES(1)) u1(.clk(clk), .reset(reset), .s(a.slave));
    pattern_serializer #(.WIDTH(W), .BIT_CYCLES(2)) u2(.clk(clk), .reset(reset), .s(b.slave));

    logic [6:0] v1, v2;
    assign v1 = {a.in_put, a.bit_valid, a.busy, a.done, a.bit_idx};
    assign v2 = {b.in_put, b.bit_valid, b.busy, b.done, b.bit_idx};

    typedef struct {
        bit act;
        bit dn;
        int t;
        logic [W-1:0] pat;
    } mdl_t;
    mdl_t m1 = '{0, 0, 0, 8'h00}, m2 = '{0, 0, 0, 8'h00};

    // model: t counts clocks since the frame's first bit; outputs follow from t by arithmetic
    function automatic mdl_t nxt(mdl_t m, logic r, logic l, logic [W-1:0] d, logic c, logic s, int bc);
        mdl_t n = m;
        if (r) n = '{0, 0, 0, 8'h00};
        else if (m.act) begin
            if (s) n.act = 0;
            else if (m.t == W * bc - 1) begin
                if (c) n.t = 0;
                else begin
                    n.act = 0;
                    n.dn = 1;
                end
            end else n.t = m.t + 1;
        end else if (m.dn) n.dn = 0;
        else if (l && !s) n = '{1, 0, 0, d};
        return n;
    endfunction

    function automatic logic [6:0] exp_of(mdl_t m, int bc);
        int k;
        if (m.dn) return 7'b0001_000;
        if (!m.act) return 7'b0;
        k = W - 1 - m.t / bc;
        return {m.pat[k], (m.t % bc) == 0, 1'b1, 1'b0, 3'(k)};
    endfunction

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic [W-1:0] d, input logic c, input logic s);
        reset = r;
        load = l;
        data = d;
        cont = c;
        stop = s;
        m1 = nxt(m1, r, l, d, c, s, 1);
        m2 = nxt(m2, r, l, d, c, s, 2);
        @(negedge clk);
        chk("model_bc1", v1, exp_of(m1, 1));
        chk("model_bc2", v2, exp_of(m2, 2));
    endtask

    typedef struct {
        logic l;
        logic [W-1:0] d;
        logic s;
        logic [6:0] e;
    } vec_t;
    vec_t tbl[12];
    int ndone;

    initial begin
        tbl[0] = '{1, 8'hAB, 0, 7'b1110_111};
        tbl[1] = '{0, 8'h00, 0, 7'b0110_110};
        tbl[2] = '{0, 8'h00, 0, 7'b1110_101};
        tbl[3] = '{0, 8'h00, 0, 7'b0110_100};
        tbl[4] = '{0, 8'h00, 0, 7'b1110_011};
        tbl[5] = '{0, 8'h00, 0, 7'b0110_010};
        tbl[6] = '{0, 8'h00, 0, 7'b1110_001};
        tbl[7] = '{0, 8'h00, 0, 7'b1110_000};
        tbl[8] = '{0, 8'h00, 0, 7'b0001_000};
        tbl[9] = '{1, 8'hFF, 0, 7'b0000_000};
        tbl[10] = '{1, 8'hFF, 1, 7'b0000_000};
        tbl[11] = '{1, 8'h0F, 0, 7'b0110_111};
        {reset, load, data, cont, stop} = '0;
        @(negedge clk);
        cyc(1, 0, 8'h00, 0, 0);
        chk("reset_state", v1, 7'b0);
        cyc(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, tbl[i].l, tbl[i].d, 0, tbl[i].s);
            chk($sformatf("vec%0d", i), v1, tbl[i].e);
        end
        cyc(0, 0, 8'h00, 0, 1);
        chk("stop_idle", v1, 7'b0);
        repeat (20) cyc(0, 0, 8'h00, 0, 0);

        cyc(0, 1, 8'hA5, 1, 0);
        ndone = 0;
        for (int i = 1; i <= 24; i++) begin
            cyc(0, 0, 8'h00, i < 20, 0);
            ndone += int'(a.done);
        end
        chk("cont_done", {6'b0, a.done}, 7'd1);
        chk("cont_ndone", 7'(ndone), 7'd1);
        repeat (30) cyc(0, 0, 8'h00, 0, 0);

        cyc(0, 1, 8'h0F, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 1, 8'hFF, 0, 0);
        chk("ignore_load", {6'b0, a.in_put}, 7'd0);
        cyc(0, 0, 8'h00, 0, 1);
        chk("stop_abort", {5'b0, a.busy, a.in_put}, 7'd0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 1, 8'h3C, 0, 0);
        chk("restart", v1, 7'b0110_111);
        repeat (20) cyc(0, 0, 8'h00, 0, 0);

        cyc(0, 1, 8'hC3, 0, 0);
        repeat (3) cyc(0, 0, 8'h00, 0, 0);
        cyc(1, 0, 8'h00, 0, 0);
        chk("reset_mid", v1 | v2, 7'b0);
        cyc(1, 1, 8'hAA, 0, 0);
        chk("reset_load", v1, 7'b0);
        cyc(0, 0, 8'h00, 0, 0);

        for (int i = 0; i < 3000; i++)
            cyc($urandom % 150 == 0, $urandom % 4 == 0, W'($urandom), $urandom % 3 != 0, $urandom % 30 == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
